// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline hazard / flush controller for the 5-stage RV32 core.
// Detects load-use and RAW hazards, counts down multi-cycle load stalls,
// freezes the pipe while data memory is busy, sequences trap/eret and
// branch flushes, and counts stalled cycles for performance monitoring.
// Optional feature macro: HAZARD_FORWARD_EN (forwarding present, so only
// load-use hazards stall; when undefined, non-load RAW hazards stall too).
module hazard_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter int NPCOP_W  = 3,
  parameter int LOAD_LAT = 1,
  parameter int PERF_W   = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [REG_AW-1:0]   ex_rd,
  input  logic                ex_memread,
  input  logic                ex_regwrite,
  input  logic [REG_AW-1:0]   mem_rd,
  input  logic                mem_regwrite,
  input  logic                dmem_req,
  input  logic                dmem_ready,
  input  logic [NPCOP_W-1:0]  npc_op,
  input  logic                int_req,
  input  logic                eret,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic                exmem_en,
  output logic                exmem_flush,
  output logic [PERF_W-1:0]   stall_cycles
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LSTALL = 2'd1,
    MWAIT  = 2'd2
  } state_t;

  // Extra stall cycles owed after the load-use detect cycle.
  localparam logic [REG_AW-1:0] CNT_INIT = REG_AW'(LOAD_LAT - 1);

  state_t              state_q, state_d;
  logic [REG_AW-1:0]   cnt_q, cnt_d;
  logic                trap_pend_q, trap_pend_d;
  logic [PERF_W-1:0]   stall_cycles_q, stall_cycles_d;

  // Unregistered control decisions before reset gating.
  logic pc_en_c, ifid_en_c, ifid_flush_c, idex_flush_c, exmem_en_c, exmem_flush_c;

  // A source register matches a producer; x0 is hard-wired and never hazards.
  function automatic logic reg_hit(input logic             rd_used,
                                   input logic [REG_AW-1:0] rs,
                                   input logic [REG_AW-1:0] rd);
    return rd_used && (rs != '0) && (rs == rd);
  endfunction

  // Saturating increment: the performance counter sticks at all-ones.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + {{(PERF_W-1){1'b0}}, 1'b1};
  endfunction

  logic ex_hit, mem_hit, load_use, raw_stall;
  logic mwait, trap, redirect, lstall_act;

  assign ex_hit   = reg_hit(id_use_rs1, id_rs1, ex_rd) || reg_hit(id_use_rs2, id_rs2, ex_rd);
  assign mem_hit  = reg_hit(id_use_rs1, id_rs1, mem_rd) || reg_hit(id_use_rs2, id_rs2, mem_rd);
  assign load_use = ex_memread && ex_regwrite && ex_hit;

`ifdef HAZARD_FORWARD_EN
  // Forwarding network resolves every non-load RAW dependency.
  logic unused_fwd;
  assign unused_fwd = mem_hit ^ mem_regwrite;
  assign raw_stall  = 1'b0;
`else
  // No forwarding: hold ID until the writer has left MEM.
  assign raw_stall  = (ex_regwrite && ex_hit) || (mem_regwrite && mem_hit);
`endif

  assign mwait      = dmem_req && !dmem_ready;
  assign trap       = int_req || eret || trap_pend_q;
  assign redirect   = (npc_op != '0);
  // A countdown interrupted by a memory freeze resumes once the freeze lifts.
  assign lstall_act = ((state_q == LSTALL) || (state_q == MWAIT)) && (cnt_q != '0);

  // Priority chain: memory freeze > trap > redirect > load stall > RAW stall.
  always_comb begin
    pc_en_c       = 1'b1;
    ifid_en_c     = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_en_c    = 1'b1;
    exmem_flush_c = 1'b0;
    state_d       = IDLE;
    cnt_d         = cnt_q;
    trap_pend_d   = trap_pend_q;

    if (mwait) begin
      pc_en_c    = 1'b0;
      ifid_en_c  = 1'b0;
      exmem_en_c = 1'b0;
      state_d    = MWAIT;
      if (int_req || eret) begin
        trap_pend_d = 1'b1;
      end
    end else if (trap) begin
      ifid_flush_c  = 1'b1;
      idex_flush_c  = 1'b1;
      exmem_flush_c = 1'b1;
      trap_pend_d   = 1'b0;
      cnt_d         = '0;
      state_d       = IDLE;
    end else if (redirect) begin
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
      cnt_d        = '0;
      state_d      = IDLE;
    end else if (lstall_act) begin
      pc_en_c      = 1'b0;
      ifid_en_c    = 1'b0;
      idex_flush_c = 1'b1;
      cnt_d        = cnt_q - 1'b1;
      state_d      = (cnt_q == REG_AW'(1)) ? IDLE : LSTALL;
    end else if (load_use) begin
      pc_en_c      = 1'b0;
      ifid_en_c    = 1'b0;
      idex_flush_c = 1'b1;
      if (LOAD_LAT > 1) begin
        cnt_d   = CNT_INIT;
        state_d = LSTALL;
      end
    end else if (raw_stall) begin
      pc_en_c      = 1'b0;
      ifid_en_c    = 1'b0;
      idex_flush_c = 1'b1;
    end
  end

  // Reset forces the pipe closed and flushed; otherwise pass the decisions through.
  always_comb begin
    if (!rstn) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_en    = 1'b0;
      exmem_flush = 1'b1;
    end else begin
      pc_en       = pc_en_c;
      ifid_en     = ifid_en_c;
      ifid_flush  = ifid_flush_c;
      idex_flush  = idex_flush_c;
      exmem_en    = exmem_en_c;
      exmem_flush = exmem_flush_c;
    end
    stall_cycles_d = pc_en_c ? stall_cycles_q : sat_inc(stall_cycles_q);
  end

  assign stall_cycles = stall_cycles_q;

  // Controller state, load countdown, pending trap and stall counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      trap_pend_q    <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      trap_pend_q    <= trap_pend_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances share stimulus, one with
// LOAD_LAT=1/PERF_W=32 and one with LOAD_LAT=3/PERF_W=4 (counter saturation).
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       id_use_rs1, id_use_rs2, ex_memread, ex_regwrite, mem_regwrite;
  logic       dmem_req, dmem_ready, int_req, eret;
  logic [2:0] npc_op;

  logic pc_en1, ifid_en1, ifid_flush1, idex_flush1, exmem_en1, exmem_flush1;
  logic pc_en3, ifid_en3, ifid_flush3, idex_flush3, exmem_en3, exmem_flush3;
  logic [31:0] sc1;
  logic [3:0]  sc3;
  logic [5:0]  outs1, outs3;

  assign outs1 = {pc_en1, ifid_en1, ifid_flush1, idex_flush1, exmem_en1, exmem_flush1};
  assign outs3 = {pc_en3, ifid_en3, ifid_flush3, idex_flush3, exmem_en3, exmem_flush3};

  // Output vectors {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, exmem_flush}
  localparam logic [5:0] O_RST   = 6'b001101;
  localparam logic [5:0] O_FRZ   = 6'b000000;
  localparam logic [5:0] O_TRAP  = 6'b111111;
  localparam logic [5:0] O_REDIR = 6'b111110;
  localparam logic [5:0] O_STALL = 6'b000110;
  localparam logic [5:0] O_RUN   = 6'b110010;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(5), .NPCOP_W(3), .LOAD_LAT(1), .PERF_W(32)) dut1 (
    .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .npc_op(npc_op), .int_req(int_req), .eret(eret), .pc_en(pc_en1),
    .ifid_en(ifid_en1), .ifid_flush(ifid_flush1), .idex_flush(idex_flush1),
    .exmem_en(exmem_en1), .exmem_flush(exmem_flush1), .stall_cycles(sc1));

  hazard_ctrl_unit #(.REG_AW(5), .NPCOP_W(3), .LOAD_LAT(3), .PERF_W(4)) dut3 (
    .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .npc_op(npc_op), .int_req(int_req), .eret(eret), .pc_en(pc_en3),
    .ifid_en(ifid_en3), .ifid_flush(ifid_flush3), .idex_flush(idex_flush3),
    .exmem_en(exmem_en3), .exmem_flush(exmem_flush3), .stall_cycles(sc3));

  // Reference model: stall cycles still owed, pending trap, stalled-cycle count.
  int     m_rem [2];
  bit     m_tp  [2];
  longint m_sc  [2];
  int     lat_of [2] = '{1, 3};
  longint sat_of [2] = '{64'hFFFF_FFFF, 64'd15};

  function automatic bit reads(bit u, logic [4:0] r, logic [4:0] rd);
    return u && (r != 5'd0) && (r == rd);
  endfunction

  function automatic bit dep_on(logic [4:0] rd);
    return reads(id_use_rs1, id_rs1, rd) || reads(id_use_rs2, id_rs2, rd);
  endfunction

  function automatic bit raw_needs_stall();
`ifdef HAZARD_FORWARD_EN
    return 1'b0;
`else
    return (ex_regwrite && dep_on(ex_rd)) || (mem_regwrite && dep_on(mem_rd));
`endif
  endfunction

  function automatic logic [5:0] model_out(int k);
    if (!rstn) return O_RST;
    if (dmem_req && !dmem_ready) return O_FRZ;
    if (int_req || eret || m_tp[k]) return O_TRAP;
    if (npc_op != 3'd0) return O_REDIR;
    if (m_rem[k] > 0) return O_STALL;
    if (ex_memread && ex_regwrite && dep_on(ex_rd)) return O_STALL;
    if (raw_needs_stall()) return O_STALL;
    return O_RUN;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0; m_tp[k] = 0; m_sc[k] = 0;
    end
  endtask

  task automatic model_commit(int k);
    logic [5:0] o;
    if (!rstn) begin
      m_rem[k] = 0; m_tp[k] = 0; m_sc[k] = 0;
      return;
    end
    o = model_out(k);
    if (!o[5] && m_sc[k] < sat_of[k]) m_sc[k]++;
    if (dmem_req && !dmem_ready) begin
      if (int_req || eret) m_tp[k] = 1;
    end else if (int_req || eret || m_tp[k]) begin
      m_tp[k] = 0; m_rem[k] = 0;
    end else if (npc_op != 3'd0) begin
      m_rem[k] = 0;
    end else if (m_rem[k] > 0) begin
      m_rem[k]--;
    end else if (ex_memread && ex_regwrite && dep_on(ex_rd)) begin
      m_rem[k] = lat_of[k] - 1;
    end
  endtask

  // Commit the model for this cycle, then move to just after the next rising edge.
  task automatic advance();
    model_commit(0);
    model_commit(1);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 5'd0; ex_memread = 0; ex_regwrite = 0;
    mem_rd = 5'd0; mem_regwrite = 0;
    dmem_req = 0; dmem_ready = 0; npc_op = 3'd0; int_req = 0; eret = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rstn = 0;
    model_clear();
    @(posedge clk);
    #1;
    rstn = 1;
  endtask

  task automatic test_reset();
    drive_idle();
    rstn = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    total++; if (outs1 !== O_RST) begin bad++; $display("FAIL rst_outs1 got=%b exp=%b", outs1, O_RST); end
    total++; if (outs3 !== O_RST) begin bad++; $display("FAIL rst_outs3 got=%b exp=%b", outs3, O_RST); end
    total++; if (sc1 !== 32'd0) begin bad++; $display("FAIL rst_sc1 got=%0d exp=0", sc1); end
    total++; if (sc3 !== 4'd0) begin bad++; $display("FAIL rst_sc3 got=%0d exp=0", sc3); end
    rstn = 1;
    #2;
    total++; if (outs1 !== O_RUN) begin bad++; $display("FAIL rst_release got=%b exp=%b", outs1, O_RUN); end
    advance();
  endtask

  task automatic test_load_use();
    do_reset();
    id_rs1 = 5'd5; id_use_rs1 = 1; ex_rd = 5'd5; ex_memread = 1; ex_regwrite = 1;
    #2;
    total++; if (outs1 !== O_STALL) begin bad++; $display("FAIL lu_detect got=%b exp=%b", outs1, O_STALL); end
    advance();
    ex_memread = 0; ex_regwrite = 0;
    #2;
    total++; if (outs1 !== O_RUN) begin bad++; $display("FAIL lu_resume got=%b exp=%b", outs1, O_RUN); end
    total++; if (sc1 !== 32'd1) begin bad++; $display("FAIL lu_count got=%0d exp=1", sc1); end
    advance();
  endtask

  task automatic test_load_lat3();
    do_reset();
    id_rs1 = 5'd7; id_use_rs1 = 1; ex_rd = 5'd7; ex_memread = 1; ex_regwrite = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      total++; if (outs3 !== O_STALL) begin bad++; $display("FAIL lat3_stall%0d got=%b exp=%b", i, outs3, O_STALL); end
      advance();
      ex_memread = 0; ex_regwrite = 0;
    end
    #2;
    total++; if (outs3 !== O_RUN) begin bad++; $display("FAIL lat3_exit got=%b exp=%b", outs3, O_RUN); end
    total++; if (sc3 !== 4'd3) begin bad++; $display("FAIL lat3_count got=%0d exp=3", sc3); end
    advance();
  endtask

  task automatic test_redirect_in_lstall();
    do_reset();
    id_rs1 = 5'd7; id_use_rs1 = 1; ex_rd = 5'd7; ex_memread = 1; ex_regwrite = 1;
    #2;
    total++; if (outs3 !== O_STALL) begin bad++; $display("FAIL rdl_detect got=%b exp=%b", outs3, O_STALL); end
    advance();
    ex_memread = 0; ex_regwrite = 0; npc_op = 3'd1;
    #2;
    total++; if (outs3 !== O_REDIR) begin bad++; $display("FAIL rdl_flush got=%b exp=%b", outs3, O_REDIR); end
    advance();
    npc_op = 3'd0;
    #2;
    total++; if (outs3 !== O_RUN) begin bad++; $display("FAIL rdl_idle got=%b exp=%b", outs3, O_RUN); end
    total++; if (sc3 !== 4'd1) begin bad++; $display("FAIL rdl_count got=%0d exp=1", sc3); end
    advance();
  endtask

  task automatic test_mwait_trap();
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      int_req = (i == 1);
      #2;
      total++; if (outs1 !== O_FRZ) begin bad++; $display("FAIL mw_freeze%0d got=%b exp=%b", i, outs1, O_FRZ); end
      advance();
    end
    int_req = 0; dmem_ready = 1;
    #2;
    total++; if (outs1 !== O_TRAP) begin bad++; $display("FAIL mw_trap got=%b exp=%b", outs1, O_TRAP); end
    advance();
    dmem_req = 0; dmem_ready = 0;
    #2;
    total++; if (outs1 !== O_RUN) begin bad++; $display("FAIL mw_after got=%b exp=%b", outs1, O_RUN); end
    total++; if (sc1 !== 32'd4) begin bad++; $display("FAIL mw_count got=%0d exp=4", sc1); end
    advance();
  endtask

  task automatic test_x0_redirect();
    do_reset();
    ex_rd = 5'd0; ex_memread = 1; ex_regwrite = 1; id_rs1 = 5'd0; id_use_rs1 = 1;
    #2;
    total++; if (outs1 !== O_RUN) begin bad++; $display("FAIL x0_nostall1 got=%b exp=%b", outs1, O_RUN); end
    total++; if (outs3 !== O_RUN) begin bad++; $display("FAIL x0_nostall3 got=%b exp=%b", outs3, O_RUN); end
    advance();
    npc_op = 3'b001;
    #2;
    total++; if (outs1 !== O_REDIR) begin bad++; $display("FAIL x0_redir got=%b exp=%b", outs1, O_REDIR); end
    advance();
    npc_op = 3'd0;
    #2;
    total++; if (outs1 !== O_RUN) begin bad++; $display("FAIL x0_after got=%b exp=%b", outs1, O_RUN); end
    advance();
  endtask

  task automatic test_raw();
    logic [5:0]  exp_o;
    logic [31:0] exp_n;
`ifdef HAZARD_FORWARD_EN
    exp_o = O_RUN;   exp_n = 32'd0;
`else
    exp_o = O_STALL; exp_n = 32'd2;
`endif
    do_reset();
    ex_rd = 5'd3; ex_regwrite = 1; id_rs2 = 5'd3; id_use_rs2 = 1;
    #2;
    total++; if (outs1 !== exp_o) begin bad++; $display("FAIL raw_ex got=%b exp=%b", outs1, exp_o); end
    advance();
    ex_regwrite = 0; mem_rd = 5'd3; mem_regwrite = 1;
    #2;
    total++; if (outs1 !== exp_o) begin bad++; $display("FAIL raw_mem got=%b exp=%b", outs1, exp_o); end
    advance();
    mem_regwrite = 0;
    #2;
    total++; if (outs1 !== O_RUN) begin bad++; $display("FAIL raw_clear got=%b exp=%b", outs1, O_RUN); end
    total++; if (sc1 !== exp_n) begin bad++; $display("FAIL raw_count got=%0d exp=%0d", sc1, exp_n); end
    advance();
  endtask

  task automatic test_reset_mid_lstall();
    do_reset();
    id_rs1 = 5'd7; id_use_rs1 = 1; ex_rd = 5'd7; ex_memread = 1; ex_regwrite = 1;
    advance();
    ex_memread = 0; ex_regwrite = 0;
    #2;
    total++; if (outs3 !== O_STALL) begin bad++; $display("FAIL mid_lstall got=%b exp=%b", outs3, O_STALL); end
    rstn = 0;
    model_clear();
    #1;
    total++; if (outs3 !== O_RST) begin bad++; $display("FAIL mid_rst3 got=%b exp=%b", outs3, O_RST); end
    total++; if (outs1 !== O_RST) begin bad++; $display("FAIL mid_rst1 got=%b exp=%b", outs1, O_RST); end
    total++; if (sc3 !== 4'd0) begin bad++; $display("FAIL mid_sc3 got=%0d exp=0", sc3); end
    advance();
    advance();
    rstn = 1;
    #2;
    total++; if (outs3 !== O_RUN) begin bad++; $display("FAIL mid_idle got=%b exp=%b", outs3, O_RUN); end
    total++; if (sc3 !== 4'd0) begin bad++; $display("FAIL mid_sc3_rel got=%0d exp=0", sc3); end
    advance();
  endtask

  task automatic test_saturation();
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    repeat (20) advance();
    #2;
    total++; if (sc1 !== 32'd20) begin bad++; $display("FAIL sat_sc1 got=%0d exp=20", sc1); end
    total++; if (sc3 !== 4'd15) begin bad++; $display("FAIL sat_sc3 got=%0d exp=15", sc3); end
    advance();
    dmem_req = 0;
    #2;
    total++; if (sc3 !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", sc3); end
    advance();
  endtask

  task automatic test_random();
    logic [5:0] e1, e3;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_use_rs1   = 1'($urandom_range(0, 1));
      id_use_rs2   = 1'($urandom_range(0, 1));
      ex_rd        = 5'($urandom_range(0, 3));
      ex_memread   = ($urandom_range(0, 2) == 0);
      ex_regwrite  = ($urandom_range(0, 3) != 0);
      mem_rd       = 5'($urandom_range(0, 3));
      mem_regwrite = ($urandom_range(0, 2) == 0);
      dmem_req     = ($urandom_range(0, 3) == 0);
      dmem_ready   = 1'($urandom_range(0, 1));
      npc_op       = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      int_req      = ($urandom_range(0, 15) == 0);
      eret         = ($urandom_range(0, 19) == 0);
      #2;
      e1 = model_out(0);
      e3 = model_out(1);
      total++; if (outs1 !== e1) begin bad++; $display("FAIL rnd_outs1 c=%0d got=%b exp=%b", c, outs1, e1); end
      total++; if (outs3 !== e3) begin bad++; $display("FAIL rnd_outs3 c=%0d got=%b exp=%b", c, outs3, e3); end
      total++; if (sc1 !== 32'(m_sc[0])) begin bad++; $display("FAIL rnd_sc1 c=%0d got=%0d exp=%0d", c, sc1, m_sc[0]); end
      total++; if (sc3 !== 4'(m_sc[1])) begin bad++; $display("FAIL rnd_sc3 c=%0d got=%0d exp=%0d", c, sc3, m_sc[1]); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_load_lat3();
    test_redirect_in_lstall();
    test_mwait_trap();
    test_x0_redirect();
    test_raw();
    test_reset_mid_lstall();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
